// File: rtl/descriptor_memory_arbiter.sv
// Two-master arbiter for a single-port descriptor RAM: round-robin between host CPU (m0)
// and DMA engine (m1), with a bounded m1 lock for read-modify-write sequences.
module descriptor_memory_arbiter #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;   // 1 = m1 was granted last
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [1:0]       rd_pending, rd_pending_nxt;   // bit 0 = m0, bit 1 = m1

    logic req0, req1, rr0, rr1, grant0, grant1, lock_full;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign lock_full = (lock_cnt == CNT_W'(LOCK_MAX));

    // Round-robin pick: on a tie the port not granted last wins
    assign rr0 = req0 & (~req1 | last_grant);
    assign rr1 = req1 & (~req0 | ~last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
            rd_pending <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
            rd_pending <= rd_pending_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        grant0       = 1'b0;
        grant1       = 1'b0;
        case (state)
            ARB: begin
                grant0       = rr0;
                grant1       = rr1;
                lock_cnt_nxt = '0;
                if (rr1 && m1_lock) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!m1_lock) begin
                    grant0       = rr0;
                    grant1       = rr1;
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else if (lock_full && req0) begin
                    // Forced release so the CPU is never starved past LOCK_MAX
                    grant0       = 1'b1;
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else begin
                    grant1 = req1;
                    if (!lock_full) begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
        if (!reset_n) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
        last_grant_nxt = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_grant);
        rd_pending_nxt = {grant1 & m1_read & ~m1_write, grant0 & m0_read & ~m0_write};
    end

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    // Memory-side mux, zeroed when idle
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end
    end

    assign mem_chipselect = grant0 | grant1;
    assign mem_clken      = reset_n;

    assign m0_readdatavalid = rd_pending[0];
    assign m1_readdatavalid = rd_pending[1];
    assign m0_readdata      = rd_pending[0] ? mem_readdata : '0;
    assign m1_readdata      = rd_pending[1] ? mem_readdata : '0;

    logic unused_be_w;
    assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_descriptor_memory_arbiter.sv
// Bench for descriptor_memory_arbiter: behavioural RAM, rule-level reference model,
// directed scenarios followed by randomized traffic.
module tb_descriptor_memory_arbiter;
    localparam int unsigned AW   = 11;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned LMAX = 16;
    localparam int unsigned DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [AW-1:0] m0_address, m1_address, mem_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
    logic m0_read, m0_write, m1_read, m1_write, m1_lock;
    logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic mem_chipselect, mem_write, mem_clken;

    always #5 clk = ~clk;

    descriptor_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // RAM: registered address, unregistered output; writes applied by tick() from DUT pins
    logic [DW-1:0] ram [0:DEPTH-1];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) if (mem_clken && mem_chipselect) ram_addr_q <= mem_address;
    assign mem_readdata = ram[ram_addr_q];

    // Reference model state
    logic [DW-1:0] shadow [0:DEPTH-1];
    bit            mlocked, mlast_m1, pend0, pend1;
    int            mcnt;
    logic [DW-1:0] pdata;

    int passed = 0, failed = 0, total = 0;
    bit act_g0, act_g1, obs_rdv0;
    logic [DW-1:0] obs_rd0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {5'h15, a, lo, 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
        m0_read = r; m0_write = w; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic drv1(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be, input bit lk);
        m1_read = r; m1_write = w; m1_address = a; m1_writedata = d; m1_byteenable = be;
        m1_lock = lk;
    endtask

    task automatic idle();
        drv0(0, 0, '0, '0, '0);
        drv1(0, 0, '0, '0, '0, 0);
    endtask

    function automatic logic [1:0] pick(input bit r0, input bit r1, input bit last_m1);
        if (r0 && r1) return last_m1 ? 2'b01 : 2'b10;
        return {r1, r0};
    endfunction

    task automatic model_reset();
        mlocked = 0; mlast_m1 = 1; mcnt = 0; pend0 = 0; pend1 = 0; pdata = '0;
    endtask

    // Called just after a falling edge with inputs driven; checks this cycle, advances one cycle
    task automatic tick();
        bit r0, r1, g0, g1, gw;
        logic [1:0] gg;
        logic [AW-1:0] ga;
        logic [BW-1:0] gbe;
        logic [DW-1:0] gd, w;
        #1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (!mlocked || !m1_lock) begin
            gg = pick(r0, r1, mlast_m1);
            g0 = gg[0]; g1 = gg[1];
        end else if (mcnt == LMAX && r0) begin
            g0 = 1; g1 = 0;
        end else begin
            g0 = 0; g1 = r1;
        end
        gw  = g0 ? m0_write : (g1 ? m1_write : 1'b0);
        ga  = g0 ? m0_address : (g1 ? m1_address : '0);
        gbe = g0 ? m0_byteenable : (g1 ? m1_byteenable : '0);
        gd  = g0 ? m0_writedata : (g1 ? m1_writedata : '0);
        chk("m0_waitrequest", 64'(m0_waitrequest), 64'(r0 && !g0));
        chk("m1_waitrequest", 64'(m1_waitrequest), 64'(r1 && !g1));
        chk("mem_chipselect", 64'(mem_chipselect), 64'(g0 || g1));
        chk("mem_write", 64'(mem_write), 64'(gw));
        chk("mem_address", 64'(mem_address), 64'(ga));
        chk("mem_byteenable", 64'(mem_byteenable), 64'(gbe));
        chk("mem_writedata", 64'(mem_writedata), 64'(gd));
        chk("mem_clken", 64'(mem_clken), 64'd1);
        chk("m0_readdatavalid", 64'(m0_readdatavalid), 64'(pend0));
        chk("m1_readdatavalid", 64'(m1_readdatavalid), 64'(pend1));
        chk("m0_readdata", 64'(m0_readdata), pend0 ? 64'(pdata) : 64'd0);
        chk("m1_readdata", 64'(m1_readdata), pend1 ? 64'(pdata) : 64'd0);
        act_g0 = r0 && !m0_waitrequest;
        act_g1 = r1 && !m1_waitrequest;
        obs_rdv0 = m0_readdatavalid;
        obs_rd0 = m0_readdata;
        if (mem_clken && mem_chipselect && mem_write)
            for (int b = 0; b < int'(BW); b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
        pend0 = g0 && m0_read && !m0_write;
        pend1 = g1 && m1_read && !m1_write;
        if (g0 || g1) begin
            mlast_m1 = g1;
            pdata = shadow[ga];
            if (gw) begin
                w = shadow[ga];
                for (int b = 0; b < int'(BW); b++) if (gbe[b]) w[8*b +: 8] = gd[8*b +: 8];
                shadow[ga] = w;
            end
        end
        if (!mlocked) begin
            if (g1 && m1_lock) begin mlocked = 1; mcnt = 1; end
        end else if (!m1_lock || (mcnt == LMAX && r0)) begin
            mlocked = 0; mcnt = 0;
        end else if (mcnt < LMAX) begin
            mcnt++;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdv0"}, 64'(m0_readdatavalid), 64'd0);
        chk({tag, "_rdv1"}, 64'(m1_readdatavalid), 64'd0);
        chk({tag, "_rd0"}, 64'(m0_readdata), 64'd0);
        chk({tag, "_rd1"}, 64'(m1_readdata), 64'd0);
        chk({tag, "_clken"}, 64'(mem_clken), 64'd0);
        chk({tag, "_cs"}, 64'(mem_chipselect), 64'd0);
        chk({tag, "_wr"}, 64'(mem_write), 64'd0);
    endtask

    initial begin
        int g0_cnt, g1_cnt, w0_run, w1_run, max_run, first_m0, max_w0;
        bit lk;
        logic [DW-1:0] exp_word;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = init_word(AW'(i));
            shadow[i] = init_word(AW'(i));
        end
        idle();
        model_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1;

        // Simultaneous reads right after reset: m0 first, then m1
        drv0(1, 0, 11'h010, '0, '0); drv1(1, 0, 11'h020, '0, '0, 0);
        tick();
        chk("tie_after_reset_m0", 64'(act_g0), 64'd1);
        drv0(0, 0, '0, '0, '0);
        tick();
        chk("second_grant_m1", 64'(act_g1), 64'd1);
        chk("m0_data_0x010", 64'(obs_rd0), 64'(init_word(11'h010)));
        idle(); tick();

        // Partial write then read back
        drv1(0, 1, 11'h7FF, 32'hDEADBEEF, 4'b0011, 0);
        tick();
        idle(); drv0(1, 0, 11'h7FF, '0, '0);
        tick();
        idle(); tick();
        exp_word = init_word(11'h7FF);
        exp_word[15:0] = 16'hBEEF;
        chk("byteenable_merge", 64'(obs_rd0), 64'(exp_word));

        // Read+write together behaves as a write
        drv0(1, 1, 11'h005, 32'h12345678, 4'hF);
        tick();
        idle(); tick();
        chk("rw_no_valid", 64'(obs_rdv0), 64'd0);
        drv0(1, 0, 11'h005, '0, '0);
        tick();
        idle(); tick();
        chk("rw_written", 64'(obs_rd0), 64'h12345678);

        // Continuous contention: strict alternation
        g0_cnt = 0; g1_cnt = 0; w0_run = 0; w1_run = 0; max_run = 0;
        for (int i = 0; i < 8; i++) begin
            drv0(1, 0, AW'(i), '0, '0); drv1(1, 0, AW'(i + 100), '0, '0, 0);
            tick();
            g0_cnt += int'(act_g0); g1_cnt += int'(act_g1);
            w0_run = act_g0 ? 0 : w0_run + 1;
            w1_run = act_g1 ? 0 : w1_run + 1;
            if (w0_run > max_run) max_run = w0_run;
            if (w1_run > max_run) max_run = w1_run;
        end
        chk("rr_m0_grants", 64'(g0_cnt), 64'd4);
        chk("rr_m1_grants", 64'(g1_cnt), 64'd4);
        chk("rr_max_wait", 64'(max_run), 64'd1);
        idle(); tick();

        // Long lock against a steady m0 request
        drv0(1, 0, 11'h001, '0, '0); tick();
        g0_cnt = 0; w0_run = 0; max_run = 0; first_m0 = -1;
        for (int i = 0; i < 40; i++) begin
            drv0(1, 0, AW'(i), '0, '0); drv1(1, 0, AW'(i + 200), '0, '0, 1);
            tick();
            if (act_g0) begin
                g0_cnt++;
                if (first_m0 < 0) first_m0 = i;
            end
            w0_run = act_g0 ? 0 : w0_run + 1;
            if (w0_run > max_run) max_run = w0_run;
        end
        chk("lock_first_m0_cycle", 64'(first_m0), 64'd16);
        chk("lock_m0_grants", 64'(g0_cnt), 64'd2);
        chk("lock_wait_bound", 64'(max_run <= int'(LMAX) + 1), 64'd1);
        idle(); tick();

        // Lock held without an m1 request still stalls m0 until forced release
        drv1(1, 0, 11'h030, '0, '0, 1); tick();
        for (int i = 0; i < 20; i++) begin
            drv0(1, 0, AW'(i), '0, '0); drv1(0, 0, '0, '0, '0, 1);
            tick();
        end
        idle(); tick();

        // Reset while a read is outstanding
        drv0(1, 0, 11'h040, '0, '0); tick();
        idle();
        reset_n = 0;
        #1;
        check_reset_outputs("midread_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1;
        tick();
        chk("no_valid_after_reset", 64'(obs_rdv0), 64'd0);
        drv0(1, 0, 11'h050, '0, '0); drv1(1, 0, 11'h060, '0, '0, 0);
        tick();
        chk("tie_after_rereset_m0", 64'(act_g0), 64'd1);

        // Randomized traffic
        lk = 0; w0_run = 0; max_w0 = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) lk = ~lk;
            drv0($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 AW'($urandom_range(0, 15)), $urandom, BW'($urandom));
            drv1($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 AW'($urandom_range(0, 15)), $urandom, BW'($urandom), lk);
            tick();
            w0_run = m0_waitrequest ? w0_run + 1 : 0;
            if (w0_run > max_w0) max_w0 = w0_run;
        end
        chk("rand_m0_wait_bound", 64'(max_w0 <= int'(LMAX) + 1), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/descriptor_memory_arbiter.md
DESCRIPTOR_MEMORY_ARBITER -- requirements
Module: descriptor_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, word address width of the descriptor memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter LOCK_MAX, default 16, maximum consecutive locked cycles before a forced release.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_address/m1_address  input  ADDR_W  requester word address (m0 = host CPU, m1 = DMA descriptor engine).
REQ-007 SHALL have ports m0_byteenable/m1_byteenable  input  DATA_W/8  write byte lanes.
REQ-008 SHALL have ports m0_read/m1_read, m0_write/m1_write  input  1  requester read/write strobes.
REQ-009 SHALL have ports m0_writedata/m1_writedata  input  DATA_W  write data.
REQ-010 SHALL have port m1_lock  input  1  DMA request to hold the grant across a read-modify-write.
REQ-011 SHALL have ports m0_waitrequest/m1_waitrequest  output  1  high = request not accepted this cycle.
REQ-012 SHALL have ports m0_readdata/m1_readdata  output  DATA_W, and m0_readdatavalid/m1_readdatavalid  output  1.
REQ-013 SHALL have memory-side ports mem_address  output  ADDR_W, mem_byteenable  output  DATA_W/8, mem_chipselect  output  1, mem_write  output  1, mem_writedata  output  DATA_W, mem_clken  output  1, mem_readdata  input  DATA_W (memory has 1-cycle read latency, registered address, unregistered output).

Function
REQ-014 SHALL treat mN_req = mN_read | mN_write; read and write together SHALL be executed as a write with no readdatavalid.
REQ-015 SHALL compute grant combinationally each cycle; exactly one requester or none is granted.
REQ-016 SHALL grant the only requester when one requests; when both request in state ARB, SHALL grant the one not recorded in register last_grant (round-robin).
REQ-017 SHALL update last_grant to the granted port on every accepted transfer.
REQ-018 SHALL drive mN_waitrequest = mN_req & ~grant_N; an idle port sees waitrequest low.
REQ-019 SHALL route the granted port's address, byteenable, writedata to memory and drive mem_chipselect = 1, mem_write = granted write, in the acceptance cycle; with no grant, mem_chipselect = 0, mem_write = 0, other mem outputs = 0.
REQ-020 SHALL drive mem_clken = 1 whenever reset_n is high.
REQ-021 SHALL register a one-hot rd_pending on an accepted read; in the following cycle SHALL assert the owner's readdatavalid for exactly one cycle and present mem_readdata on its readdata; non-valid readdata SHALL be 0.
REQ-022 SHALL sustain back-to-back accepted reads (one per cycle) with each readdatavalid exactly one cycle after its acceptance.
REQ-023 SHALL implement state machine states ARB and LOCKED.
REQ-024 ARB -> LOCKED when m1 is granted and m1_lock = 1; lock_cnt loads 1.
REQ-025 In LOCKED, m1 SHALL have absolute priority; m0 SHALL be stalled; lock_cnt increments each cycle, saturating at LOCK_MAX.
REQ-026 LOCKED -> ARB when m1_lock = 0 (in that cycle normal round-robin applies), or when lock_cnt = LOCK_MAX and m0_req = 1; in the forced case m0 SHALL be granted that cycle and last_grant set to m0.
REQ-027 At lock_cnt = LOCK_MAX with m0_req = 0, SHALL remain LOCKED until m0 requests or m1_lock drops.
REQ-028 m1_lock without a m1 request SHALL still hold LOCKED state but grant nothing to m0 until release per REQ-026.
REQ-029 Writes SHALL complete in the acceptance cycle; no write response is generated.

Reset
REQ-030 While reset_n = 0: state = ARB, last_grant = m1, lock_cnt = 0, rd_pending = 0, all readdatavalid = 0, readdata = 0, mem_clken = 0, mem_chipselect = 0, mem_write = 0.
REQ-031 Reset asserted with a read outstanding SHALL discard it; no readdatavalid after reset release.
REQ-032 First cycle after release SHALL arbitrate normally (m0 wins a simultaneous tie).

Verification
REQ-033 Simultaneous reads m0 @0x010, m1 @0x020 after reset -> m0 accepted cycle 0, m1 cycle 1; readdatavalid m0 cycle 1, m1 cycle 2 with matching memory words.
REQ-034 m1 write 0xDEADBEEF byteenable 4'b0011 @0x7FF, then m0 read 0x7FF -> readdata low half 0xBEEF, upper half unchanged.
REQ-035 Both ports request continuously for 8 cycles -> grants strictly alternate, 4 each, no waitrequest starvation above 1 cycle.
REQ-036 m1_lock held 40 cycles with m0 requesting -> m0 granted exactly on cycle 16 of lock, then lock resumes; m0 never waits more than LOCK_MAX+1 cycles.
REQ-037 reset_n pulsed low in the cycle after m0 read accept -> m0_readdatavalid stays 0; all outputs at REQ-030 values.
REQ-038 Simultaneous m0_read and m0_write @0x005 -> memory written, no m0_readdatavalid.
